task_pop_dispatcher: RTL

// - Consumer-side partner of the task generator: issues pop requests, captures the (tree_id, data) returned a fixed latency later, and delivers each task on a valid/ready stream.
// - Credit scheme: a pop is issued only when the output FIFO has room for it, counting tasks still in flight. Tasks are never dropped under downstream backpressure.
// - Sits between the task generator's pop port and the per-tree scheduler / egress logic.

---
 rtl/task_pkg.sv | 16 +
 rtl/task_pop_dispatcher_if.sv | 14 +
 rtl/sync_fifo_fwft.sv | 54 +++++
 rtl/task_pop_dispatcher.sv | 96 +++++++++
 4 files changed

// File: rtl/task_pkg.sv
// Shared task types for the task generator / dispatcher pair.
// A task is the tree id it belongs to plus its metadata-and-priority payload.
package task_pkg;

  localparam int PTW           = 16;
  localparam int TREE_NUM      = 5;
  localparam int TREE_NUM_BITS = $clog2(TREE_NUM);
  localparam int MTW           = TREE_NUM_BITS;
  localparam int DW            = MTW + PTW;

  typedef struct packed {
    logic [TREE_NUM_BITS-1:0] tree_id;
    logic [DW-1:0]            data;
  } task_t;

endpackage

// File: rtl/task_pop_dispatcher_if.sv
// Downstream task stream of the pop dispatcher: valid/ready with tree id and data.
// The dispatcher drives the master side; the scheduler/egress logic is the slave.
interface task_pop_dispatcher_if;
  import task_pkg::*;

  logic                     o_valid;
  logic                     i_ready;
  logic [TREE_NUM_BITS-1:0] o_tree_id;
  logic [DW-1:0]            o_data;

  modport master (output o_valid, output o_tree_id, output o_data, input i_ready);
  modport slave  (input o_valid, input o_tree_id, input o_data, output i_ready);

endinterface

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with wrap-around pointers and an extra
// count bit; the output holds the last read entry while the FIFO is empty.
module sync_fifo_fwft #(
  parameter type entry_t = logic [7:0],
  parameter int  DEPTH   = 4,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   wr_en,
  input  entry_t wr_data,
  input  logic   rd_en,
  output entry_t rd_data,
  output logic   empty,
  output logic   full,
  output logic [AW:0] count
);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  entry_t      mem [DEPTH];
  entry_t      last_q;
  logic        wr_ok;
  logic        rd_ok;

  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  // A write into a full FIFO only proceeds when the head leaves in the same cycle.
  assign wr_ok = wr_en & (~full | rd_en);
  assign rd_ok = rd_en & ~empty;

  assign rd_data = empty ? last_q : mem[rd_ptr[AW-1:0]];

  // NOTE: storage carries no reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_q <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/task_pop_dispatcher.sv
// Issues credit-limited pops to the task generator, captures returns after POP_LAT
// cycles and delivers them in issue order on a valid/ready stream.
module task_pop_dispatcher
  import task_pkg::*;
#(
  parameter int  POP_LAT   = 2,
  parameter int  OUT_DEPTH = 4,
  parameter int  MIN_GAP   = 1,
  localparam int IFW       = $clog2(POP_LAT + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic                     i_en,
  input  logic                     i_tg_empty,
  output logic                     o_pop,
  input  logic [TREE_NUM_BITS-1:0] i_pop_tree_id,
  input  logic [DW-1:0]            i_pop_data,
  task_pop_dispatcher_if.master    out_if,
  output logic [IFW-1:0]           o_inflight,
  output logic [31:0]              o_pop_cnt
);

  localparam int CW = $clog2(OUT_DEPTH) + 1;
  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  logic [POP_LAT-1:0] tag_q;
  logic [GW-1:0]      gap_q;
  logic [CW-1:0]      fifo_count;
  logic               fifo_empty;
  logic               fifo_full;
  logic               credit_ok;
  logic               ret;
  logic               rd_en;
  task_t              wr_task;
  task_t              rd_task;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned.
  always_comb begin
    credit_ok = 1'b0;
    o_pop     = 1'b0;
    // Tasks still in flight already own a FIFO slot.
    credit_ok = (int'(fifo_count) + int'(o_inflight)) < OUT_DEPTH;
    o_pop     = i_arst_n & i_en & ~i_tg_empty & credit_ok & (gap_q == '0);
  end

  assign ret     = tag_q[POP_LAT-1];
  assign rd_en   = ~fifo_empty & out_if.i_ready;
  assign wr_task = '{tree_id: i_pop_tree_id, data: i_pop_data};

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      tag_q      <= '0;
      gap_q      <= '0;
      o_inflight <= '0;
      o_pop_cnt  <= '0;
    end else begin
      tag_q[0] <= o_pop;
      for (int i = 1; i < POP_LAT; i++) tag_q[i] <= tag_q[i-1];

      if (o_pop)             gap_q <= GW'(MIN_GAP - 1);
      else if (gap_q != '0)  gap_q <= gap_q - GW'(1);

      case ({o_pop, ret})
        2'b10:   o_inflight <= o_inflight + IFW'(1);
        2'b01:   o_inflight <= o_inflight - IFW'(1);
        default: o_inflight <= o_inflight;
      endcase

      if (o_pop) o_pop_cnt <= o_pop_cnt + 32'd1;
    end
  end

  sync_fifo_fwft #(
    .entry_t (task_t),
    .DEPTH   (OUT_DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_arst_n),
    .wr_en   (ret),
    .wr_data (wr_task),
    .rd_en   (rd_en),
    .rd_data (rd_task),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign out_if.o_valid   = ~fifo_empty;
  assign out_if.o_tree_id = rd_task.tree_id;
  assign out_if.o_data    = rd_task.data;

  // A return landing on a full FIFO with no departing head means credit was miscounted.
  assert property (@(posedge i_clk) disable iff (!i_arst_n) !(ret && fifo_full && !rd_en));

endmodule
